// File: rtl/hazard_controller.sv
// hazard_controller
// Pipeline hazard sequencer for the 5-stage MIPS datapath. It generates the
// ID-stage control-bubble select, the PC and IF/ID write enables, the IF/ID
// flush and a global pipeline hold for the later stages.
//
// Behaviour in brief:
//   - Detects a load-use hazard against the load currently in EX and inserts
//     LOAD_STALL_CYCLES bubbles.
//   - Flushes IF/ID on a taken branch, j/jal or jr.
//   - Freezes the whole pipeline while data memory reports busy. The stall
//     context is kept, so a freeze neither adds to nor uses up the bubble count.
//
// Parameters:
//   LOAD_STALL_CYCLES  bubbles per load-use hazard (1..3)
//   CNT_W              statistics counter width (only with HAZARD_STATS_EN)
//
// Ports:
//   Clk, Rst                       clock, asynchronous active-low reset
//   IFID_Rs, IFID_Rt, IFID_UsesRt  source registers of the ID instruction
//   IDEX_MemRead, IDEX_WriteReg    load flag and destination of the EX instruction
//   BranchTaken, Jump, Jr          control transfer resolved in ID
//   MemBusy                        data memory freeze request
//   PCWrite, IFIDWrite             PC / IF/ID load enables
//   IFIDFlush                      clear IF/ID to a nop on the next edge
//   controlMuxSignal               1 = pass decoded control, 0 = bubble
//   PipeHold                       hold ID/EX, EX/MEM and MEM/WB
//   StallCount, FlushCount         saturating statistics (HAZARD_STATS_EN only)
//
// Configuration macro: HAZARD_STATS_EN adds the statistics counters.
module hazard_controller #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [4:0] IFID_Rs,
  input  logic [4:0] IFID_Rt,
  input  logic       IFID_UsesRt,
  input  logic [1:0] IDEX_MemRead,
  input  logic [4:0] IDEX_WriteReg,
  input  logic       BranchTaken,
  input  logic       Jump,
  input  logic       Jr,
  input  logic       MemBusy,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IFIDFlush,
  output logic       controlMuxSignal,
  output logic       PipeHold
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
`endif
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } stateT;

  // Reject parameter values the 2-bit remain counter cannot represent.
  if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 3 || CNT_W < 1) begin : gBadParams
    $error("hazard_controller: illegal LOAD_STALL_CYCLES or CNT_W");
  end

  stateT      state_r, nextState_s, effState_s;
  logic [1:0] remain_r, nextRemain_s;
  logic       hazard_s;
  logic       transfer_s;

  // Load-use detection; $0 is hard-wired to zero and never hazards.
  always_comb begin
    hazard_s = (IDEX_MemRead != 2'b00) && (IDEX_WriteReg != 5'd0) &&
               ((IDEX_WriteReg == IFID_Rs) ||
                (IFID_UsesRt && (IDEX_WriteReg == IFID_Rt)));
    transfer_s = BranchTaken | Jump | Jr;
  end

  // Once memory releases, MEM_WAIT behaves as the context it interrupted.
  // A non-zero remain means a load stall was in progress.
  always_comb begin
    effState_s = state_r;
    if (state_r == MEM_WAIT) begin
      effState_s = (remain_r != 2'd0) ? LOAD_STALL : RUN;
    end else begin
      effState_s = state_r;
    end
  end

  // State and bubble-counter register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r  <= RUN;
      remain_r <= 2'd0;
    end else begin
      state_r  <= nextState_s;
      remain_r <= nextRemain_s;
    end
  end

  // Next-state logic. A memory freeze parks the FSM and keeps remain intact.
  always_comb begin
    nextState_s  = state_r;
    nextRemain_s = remain_r;
    if (MemBusy) begin
      nextState_s  = MEM_WAIT;
      nextRemain_s = remain_r;
    end else begin
      case (effState_s)
        LOAD_STALL: begin
          if (remain_r <= 2'd1) begin
            nextState_s  = RUN;
            nextRemain_s = 2'd0;
          end else begin
            nextState_s  = LOAD_STALL;
            nextRemain_s = remain_r - 2'd1;
          end
        end
        RUN: begin
          // The first bubble is issued in RUN, so LOAD_STALL covers the rest.
          if (hazard_s && (LOAD_STALL_CYCLES > 1)) begin
            nextState_s  = LOAD_STALL;
            nextRemain_s = 2'(LOAD_STALL_CYCLES - 1);
          end else begin
            nextState_s  = RUN;
            nextRemain_s = 2'd0;
          end
        end
        default: begin
          nextState_s  = RUN;
          nextRemain_s = 2'd0;
        end
      endcase
    end
  end

  // Output decode. The priority is reset, memory freeze, stall, control
  // transfer, then normal flow. A transfer hidden behind a stall is flushed
  // later, once the stalled instruction proceeds.
  always_comb begin
    PCWrite          = 1'b0;
    IFIDWrite        = 1'b0;
    IFIDFlush        = 1'b0;
    controlMuxSignal = 1'b0;
    PipeHold         = 1'b0;
    if (!Rst) begin
      PCWrite          = 1'b0;
      controlMuxSignal = 1'b0;
    end else if (MemBusy) begin
      PipeHold         = 1'b1;
      controlMuxSignal = 1'b1;
    end else if ((effState_s == LOAD_STALL) || hazard_s) begin
      controlMuxSignal = 1'b0;
    end else if (transfer_s) begin
      PCWrite          = 1'b1;
      IFIDWrite        = 1'b1;
      IFIDFlush        = 1'b1;
      controlMuxSignal = 1'b1;
    end else begin
      PCWrite          = 1'b1;
      IFIDWrite        = 1'b1;
      controlMuxSignal = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating bubble and flush counters. Edges taken while Rst is low are
  // covered by the asynchronous clear.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      StallCount <= {CNT_W{1'b0}};
      FlushCount <= {CNT_W{1'b0}};
    end else begin
      if (!controlMuxSignal && (StallCount != CNT_MAX)) begin
        StallCount <= StallCount + CNT_ONE;
      end else begin
        StallCount <= StallCount;
      end
      if (IFIDFlush && (FlushCount != CNT_MAX)) begin
        FlushCount <= FlushCount + CNT_ONE;
      end else begin
        FlushCount <= FlushCount;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller.
// Two instances run side by side on the same stimulus: one with
// LOAD_STALL_CYCLES=1 and one with LOAD_STALL_CYCLES=3.
// Each table row is one clock cycle of inputs. It carries the expected outputs
// of both instances, packed as {PCWrite, IFIDWrite, IFIDFlush,
// controlMuxSignal, PipeHold}.
// Rows are pushed to a scoreboard when driven and compared on the falling edge.
module tb_hazard_controller;

  localparam int CW = 16;

  localparam logic [4:0] NORM  = 5'b11010;
  localparam logic [4:0] BUB   = 5'b00000;
  localparam logic [4:0] FLSH  = 5'b11110;
  localparam logic [4:0] HOLD  = 5'b00011;
  localparam logic [4:0] RSTV  = 5'b00000;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic [1:0] memRead;
    logic [4:0] writeReg;
    logic       br;
    logic       jmp;
    logic       jr;
    logic       busy;
    logic [4:0] exp1;
    logic [4:0] exp3;
  } vecT;

  typedef struct {
    int         idx;
    logic [4:0] exp1;
    logic [4:0] exp3;
  } sbT;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [4:0] rs = 5'd0, rt = 5'd0, writeReg = 5'd0;
  logic       usesRt = 1'b0, br = 1'b0, jmp = 1'b0, jr = 1'b0, busy = 1'b0;
  logic [1:0] memRead = 2'b00;

  logic pcw1, ifw1, fl1, cms1, ph1;
  logic pcw3, ifw3, fl3, cms3, ph3;
`ifdef HAZARD_STATS_EN
  logic [CW-1:0] stall1, flush1, stall3, flush3;
`endif

  int nChecks = 0;
  int nFails  = 0;

  vecT vecs[$];
  sbT  sbQ[$];

  always #5 Clk = ~Clk;

  hazard_controller #(.LOAD_STALL_CYCLES(1), .CNT_W(CW)) dut1 (
    .Clk(Clk), .Rst(Rst), .IFID_Rs(rs), .IFID_Rt(rt), .IFID_UsesRt(usesRt),
    .IDEX_MemRead(memRead), .IDEX_WriteReg(writeReg), .BranchTaken(br),
    .Jump(jmp), .Jr(jr), .MemBusy(busy), .PCWrite(pcw1), .IFIDWrite(ifw1),
    .IFIDFlush(fl1), .controlMuxSignal(cms1), .PipeHold(ph1)
`ifdef HAZARD_STATS_EN
    , .StallCount(stall1), .FlushCount(flush1)
`endif
  );

  hazard_controller #(.LOAD_STALL_CYCLES(3), .CNT_W(CW)) dut3 (
    .Clk(Clk), .Rst(Rst), .IFID_Rs(rs), .IFID_Rt(rt), .IFID_UsesRt(usesRt),
    .IDEX_MemRead(memRead), .IDEX_WriteReg(writeReg), .BranchTaken(br),
    .Jump(jmp), .Jr(jr), .MemBusy(busy), .PCWrite(pcw3), .IFIDWrite(ifw3),
    .IFIDFlush(fl3), .controlMuxSignal(cms3), .PipeHold(ph3)
`ifdef HAZARD_STATS_EN
    , .StallCount(stall3), .FlushCount(flush3)
`endif
  );

  task automatic addRow(input logic r, input logic [4:0] s, input logic [4:0] t,
                        input logic u, input logic [1:0] m, input logic [4:0] w,
                        input logic b, input logic j, input logic jrr,
                        input logic mb, input logic [4:0] e1, input logic [4:0] e3);
    vecT v;
    v.rst = r; v.rs = s; v.rt = t; v.usesRt = u; v.memRead = m; v.writeReg = w;
    v.br = b; v.jmp = j; v.jr = jrr; v.busy = mb; v.exp1 = e1; v.exp3 = e3;
    vecs.push_back(v);
  endtask

  // No hazard: a load to $8 is in EX, but ID reads $1 and $2.
  task automatic rowN(input logic b, input logic j, input logic jrr, input logic mb,
                      input logic [4:0] e1, input logic [4:0] e3);
    addRow(1'b1, 5'd1, 5'd2, 1'b1, 2'b01, 5'd8, b, j, jrr, mb, e1, e3);
  endtask

  // Load-use hazard: a load to $8 is in EX and ID reads $8 as rs.
  task automatic rowH(input logic b, input logic mb,
                      input logic [4:0] e1, input logic [4:0] e3);
    addRow(1'b1, 5'd8, 5'd2, 1'b1, 2'b01, 5'd8, b, 1'b0, 1'b0, mb, e1, e3);
  endtask

  // Scoreboard consumer: compares both instances away from the rising edge.
  always @(negedge Clk) begin
    if (sbQ.size() > 0) begin
      sbT e;
      logic [4:0] got1, got3;
      e = sbQ.pop_front();
      got1 = {pcw1, ifw1, fl1, cms1, ph1};
      got3 = {pcw3, ifw3, fl3, cms3, ph3};
      nChecks++;
      if (got1 !== e.exp1) begin
        nFails++;
        $display("FAIL row%0d lsc1 outputs got %b want %b", e.idx, got1, e.exp1);
      end
      nChecks++;
      if (got3 !== e.exp3) begin
        nFails++;
        $display("FAIL row%0d lsc3 outputs got %b want %b", e.idx, got3, e.exp3);
      end
    end
  end

  initial begin
    int s1 = 0, s3 = 0, f1 = 0, f3 = 0;
    int waitCnt = 0;

    // ---- vector table ----
    addRow(1'b0, 5'd8, 5'd2, 1'b1, 2'b01, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, RSTV, RSTV); // 0 reset
    rowN(1'b0, 1'b0, 1'b0, 1'b0, NORM, NORM);            // 1
    rowH(1'b0, 1'b0, BUB, BUB);                          // 2 hazard
    rowN(1'b0, 1'b0, 1'b0, 1'b0, NORM, BUB);             // 3
    rowN(1'b0, 1'b0, 1'b0, 1'b0, NORM, BUB);             // 4
    rowN(1'b0, 1'b0, 1'b0, 1'b0, NORM, NORM);            // 5
    addRow(1'b1, 5'd0, 5'd0, 1'b1, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM, NORM); // 6 $0
    addRow(1'b1, 5'd1, 5'd9, 1'b0, 2'b01, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, NORM, NORM); // 7 rt unused
    addRow(1'b1, 5'd1, 5'd9, 1'b1, 2'b01, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, BUB, BUB);   // 8 rt hazard
    rowN(1'b0, 1'b0, 1'b0, 1'b0, NORM, BUB);             // 9
    rowN(1'b0, 1'b0, 1'b0, 1'b0, NORM, BUB);             // 10
    rowN(1'b1, 1'b0, 1'b0, 1'b0, FLSH, FLSH);            // 11 branch
    rowN(1'b0, 1'b0, 1'b0, 1'b0, NORM, NORM);            // 12
    rowN(1'b0, 1'b1, 1'b0, 1'b0, FLSH, FLSH);            // 13 jump
    rowN(1'b0, 1'b0, 1'b1, 1'b0, FLSH, FLSH);            // 14 jr
    rowH(1'b1, 1'b0, BUB, BUB);                          // 15 branch + hazard
    rowN(1'b1, 1'b0, 1'b0, 1'b0, FLSH, BUB);             // 16
    rowN(1'b1, 1'b0, 1'b0, 1'b0, FLSH, BUB);             // 17
    rowN(1'b1, 1'b0, 1'b0, 1'b0, FLSH, FLSH);            // 18
    rowN(1'b0, 1'b0, 1'b0, 1'b0, NORM, NORM);            // 19
    rowH(1'b0, 1'b0, BUB, BUB);                          // 20 stall then freeze
    rowN(1'b0, 1'b0, 1'b0, 1'b0, NORM, BUB);             // 21
    for (int i = 0; i < 4; i++) rowN(1'b0, 1'b0, 1'b0, 1'b1, HOLD, HOLD); // 22-25
    rowN(1'b0, 1'b0, 1'b0, 1'b0, NORM, BUB);             // 26 last bubble
    rowN(1'b0, 1'b0, 1'b0, 1'b0, NORM, NORM);            // 27
    rowH(1'b0, 1'b1, HOLD, HOLD);                        // 28 freeze over hazard
    rowH(1'b0, 1'b0, BUB, BUB);                          // 29
    rowN(1'b0, 1'b0, 1'b0, 1'b0, NORM, BUB);             // 30
    addRow(1'b0, 5'd1, 5'd2, 1'b1, 2'b01, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, RSTV, RSTV); // 31 reset mid-stall
    rowN(1'b0, 1'b0, 1'b0, 1'b0, NORM, NORM);            // 32 stall abandoned
    rowN(1'b1, 1'b0, 1'b0, 1'b1, HOLD, HOLD);            // 33 freeze over branch
    rowN(1'b1, 1'b0, 1'b0, 1'b0, FLSH, FLSH);            // 34
    rowN(1'b0, 1'b0, 1'b0, 1'b0, NORM, NORM);            // 35
    addRow(1'b1, 5'd8, 5'd2, 1'b0, 2'b10, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, BUB, BUB);   // 36 MemRead=10
    rowN(1'b0, 1'b0, 1'b0, 1'b0, NORM, BUB);             // 37
    rowN(1'b0, 1'b0, 1'b0, 1'b0, NORM, BUB);             // 38
    rowN(1'b0, 1'b0, 1'b0, 1'b0, NORM, NORM);            // 39

    // ---- apply ----
    for (int i = 0; i < vecs.size(); i++) begin
      sbT e;
      @(posedge Clk);
      #1;
      Rst = vecs[i].rst; rs = vecs[i].rs; rt = vecs[i].rt; usesRt = vecs[i].usesRt;
      memRead = vecs[i].memRead; writeReg = vecs[i].writeReg; br = vecs[i].br;
      jmp = vecs[i].jmp; jr = vecs[i].jr; busy = vecs[i].busy;
      e.idx = i; e.exp1 = vecs[i].exp1; e.exp3 = vecs[i].exp3;
      sbQ.push_back(e);
      // Counter model: expected counts follow the expected outputs of each row.
      if (!vecs[i].rst) begin
        s1 = 0; s3 = 0; f1 = 0; f3 = 0;
      end else begin
        if (!vecs[i].exp1[1]) s1++;
        if (!vecs[i].exp3[1]) s3++;
        if (vecs[i].exp1[2]) f1++;
        if (vecs[i].exp3[2]) f3++;
      end
`ifdef HAZARD_STATS_EN
      if (i == 31) begin
        #1;
        nChecks++;
        if (stall1 !== '0 || flush1 !== '0 || stall3 !== '0 || flush3 !== '0) begin
          nFails++;
          $display("FAIL reset_counters got %0d %0d %0d %0d want 0 0 0 0",
                   stall1, flush1, stall3, flush3);
        end
      end
`endif
    end

    // Let the final row's rising edge update the state and counters.
    @(posedge Clk);
    #1;
    while (sbQ.size() > 0 && waitCnt < 10) begin
      @(posedge Clk);
      waitCnt++;
    end
    if (sbQ.size() > 0) begin
      nChecks++;
      nFails++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sbQ.size());
    end

`ifdef HAZARD_STATS_EN
    nChecks++;
    if (stall1 !== CW'(s1) || stall3 !== CW'(s3)) begin
      nFails++;
      $display("FAIL stall_count got %0d/%0d want %0d/%0d", stall1, stall3, s1, s3);
    end
    nChecks++;
    if (flush1 !== CW'(f1) || flush3 !== CW'(f3)) begin
      nFails++;
      $display("FAIL flush_count got %0d/%0d want %0d/%0d", flush1, flush3, f1, f3);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
